// File: rtl/ctx_wrq_sched_if.sv
// SRAM write-port bundle between the write scheduler and the SRAM controller.
//   BUS_RDY          controller -> scheduler  write port ready
//   BUS_WRQ          scheduler  -> controller single-cycle write strobe
//   ROM_ADDR         scheduler  -> controller 24-bit write address
//   ROM_DATA         scheduler  -> controller 16-bit write data
//   ROM_WORD_ENABLE  scheduler  -> controller word-write flag
interface ctx_wrq_sched_if;
  logic        BUS_RDY;
  logic        BUS_WRQ;
  logic [23:0] ROM_ADDR;
  logic [15:0] ROM_DATA;
  logic        ROM_WORD_ENABLE;

  modport master (
    input  BUS_RDY,
    output BUS_WRQ,
    output ROM_ADDR,
    output ROM_DATA,
    output ROM_WORD_ENABLE
  );

  modport slave (
    output BUS_RDY,
    input  BUS_WRQ,
    input  ROM_ADDR,
    input  ROM_DATA,
    input  ROM_WORD_ENABLE
  );
endinterface

// File: rtl/ctx_wrq_sched.sv
// Write-request scheduler between the SNES context-capture logic and the
// shared SRAM write port. Captures are queued in a FIFO and the port is
// arbitrated against an alternate (MCU bulk/restore) requester with
// starvation protection. One write is issued per BUS_RDY window.
//
// Ports:
//   clkin, reset        clock, synchronous active-high reset
//   CAP_REQ/ADDR/DATA/WORD  capture push strobe and payload
//   CAP_FULL            FIFO holds 2^DEPTH_LOG2 entries
//   CAP_OVF             sticky: a push was dropped (cleared by FLUSH)
//   FIFO_LEVEL          current entry count
//   FLUSH               discard queued capture entries
//   ALT_REQ/ADDR/DATA/WORD  alternate requester (level request)
//   ALT_ACK             pulse coincident with the alternate write strobe
//   bus                 SRAM write port (ctx_wrq_sched_if.master)
//
// Optional feature macro: CTX_WRQ_COALESCE_EN
//   When defined, a push matching the queued tail entry's address and word
//   flag overwrites that entry's data instead of allocating a new one.
module ctx_wrq_sched #(
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clkin,
  input  logic                  reset,
  input  logic                  CAP_REQ,
  input  logic [23:0]           CAP_ADDR,
  input  logic [15:0]           CAP_DATA,
  input  logic                  CAP_WORD,
  output logic                  CAP_FULL,
  output logic                  CAP_OVF,
  output logic [DEPTH_LOG2:0]   FIFO_LEVEL,
  input  logic                  FLUSH,
  input  logic                  ALT_REQ,
  input  logic [23:0]           ALT_ADDR,
  input  logic [15:0]           ALT_DATA,
  input  logic                  ALT_WORD,
  output logic                  ALT_ACK,
  ctx_wrq_sched_if.master       bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic        word;
    logic [23:0] addr;
    logic [15:0] data;
  } wr_ent_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CAP = 1'b0,
    GNT_ALT = 1'b1
  } grant_t;

  state_t          state;
  grant_t          grant;
  wr_ent_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] starve_cnt;
  logic            ovf_q;
  logic [23:0]     rom_addr_q;
  logic [15:0]     rom_data_q;
  logic            rom_word_q;

  logic            fifo_empty_c;
  logic            fifo_full_c;
  logic            cap_avail_c;
  logic            alt_win_c;
  logic            start_c;
  logic            sel_cap_c;
  logic            wrq_c;
  logic            pop_c;
  logic            ack_c;
  logic            merge_c;
  logic            push_c;
  logic            drop_c;
  wr_ent_t         head_c;
  wr_ent_t         cap_ent_c;

  // Source selection and strobe generation
  always_comb begin
    fifo_empty_c = (level == '0);
    fifo_full_c  = (level == LVL_W'(DEPTH));
    // A flushing FIFO offers nothing to the arbiter this cycle
    cap_avail_c  = !fifo_empty_c && !FLUSH;
    alt_win_c    = ALT_REQ && (!cap_avail_c || (starve_cnt == CNT_W'(STARVE_MAX)));
    start_c      = (state == IDLE) && bus.BUS_RDY && (cap_avail_c || ALT_REQ);
    sel_cap_c    = start_c && !alt_win_c;
    wrq_c        = !reset && (state == ISSUE) && bus.BUS_RDY &&
                   !(FLUSH && (grant == GNT_CAP));
    pop_c        = wrq_c && (grant == GNT_CAP);
    ack_c        = wrq_c && (grant == GNT_ALT);
    head_c       = mem[rd_ptr];
    cap_ent_c    = '{word: CAP_WORD, addr: CAP_ADDR, data: CAP_DATA};
  end

`ifdef CTX_WRQ_COALESCE_EN
  logic [23:0] tail_addr;
  logic        tail_word;
  logic        tail_locked_c;

  // Tail is untouchable once it is the head and owns the ROM_* registers
  always_comb begin
    tail_locked_c = (level == LVL_W'(1)) &&
                    (((state == ISSUE) && (grant == GNT_CAP)) || sel_cap_c);
    merge_c       = CAP_REQ && !FLUSH && !fifo_empty_c && !tail_locked_c &&
                    (CAP_ADDR == tail_addr) && (CAP_WORD == tail_word);
  end

  // Address/word of the most recently allocated entry
  always_ff @(posedge clkin) begin
    if (reset) begin
      tail_addr <= '0;
      tail_word <= 1'b0;
    end else if (push_c) begin
      tail_addr <= CAP_ADDR;
      tail_word <= CAP_WORD;
    end
  end
`else
  assign merge_c = 1'b0;
`endif

  // Push accepted when space exists or the head leaves in the same cycle
  always_comb begin
    push_c = CAP_REQ && !FLUSH && !merge_c && (!fifo_full_c || pop_c);
    drop_c = CAP_REQ && !FLUSH && !merge_c && !push_c;
  end

  // FIFO storage (no reset needed; validity tracked by level)
  always_ff @(posedge clkin) begin
    if (push_c) begin
      mem[wr_ptr] <= cap_ent_c;
    end
`ifdef CTX_WRQ_COALESCE_EN
    else if (merge_c) begin
      mem[wr_ptr - PTR_W'(1)].data <= CAP_DATA;
    end
`endif
  end

  // FIFO control, arbitration and write FSM
  always_ff @(posedge clkin) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= GNT_CAP;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      starve_cnt <= '0;
      ovf_q      <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      rom_word_q <= 1'b0;
    end else begin
      if (FLUSH) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
        level <= level + LVL_W'(push_c) - LVL_W'(pop_c);
        if (drop_c) ovf_q <= 1'b1;
      end

      // Counts capture wins while the alternate requester is waiting
      if (!ALT_REQ || ack_c) begin
        starve_cnt <= '0;
      end else if (pop_c && (starve_cnt != CNT_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (start_c) begin
            if (alt_win_c) begin
              grant      <= GNT_ALT;
              rom_addr_q <= ALT_ADDR;
              rom_data_q <= ALT_DATA;
              rom_word_q <= ALT_WORD;
            end else begin
              grant      <= GNT_CAP;
              rom_addr_q <= head_c.addr;
              rom_data_q <= head_c.data;
              rom_word_q <= head_c.word;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if ((grant == GNT_CAP) && FLUSH) begin
            state <= IDLE;
          end else if (bus.BUS_RDY) begin
            state <= HOLD;
          end
        end
        HOLD: begin
          // Controller drops RDY after the strobe; ignore it for one cycle
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.BUS_WRQ         = wrq_c;
  assign bus.ROM_ADDR        = rom_addr_q;
  assign bus.ROM_DATA        = rom_data_q;
  assign bus.ROM_WORD_ENABLE = rom_word_q;
  assign ALT_ACK             = ack_c;
  assign CAP_FULL            = fifo_full_c;
  assign CAP_OVF             = ovf_q;
  assign FIFO_LEVEL          = level;

endmodule
